pio_in_capture: RTL and testbench

Parametrised Avalon-MM input port for the NIOSIIe system: samples a WIDTH-bit asynchronous input bus through a two-stage synchroniser and exposes it as a read-only data register. Per-bit edge detection sets sticky edge-capture bits, which are gated by an interrupt mask to drive a registered `irq` to the CPU. It replaces the plain input port used for `ram_din`-style status inputs wherever software needs edge events or interrupts rather than polling.

---
 rtl/pio_in_capture.sv | 108 ++++++++++
 tb/tb_pio_in_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_capture.sv
// Avalon-MM input port: synchronised data register, per-bit sticky edge capture,
// interrupt mask and a registered edge- or level-sensitive interrupt request.
module pio_in_capture #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_TYPE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_EDGE = 2'd2,
    ADDR_NONE = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [1:0]       prime_cnt;

  logic             wr_en;
  logic             primed;
  logic [WIDTH-1:0] edge_cond;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] edge_next;
  logic [31:0]      read_mux;
  logic             irq_next;
  logic [31:0]      writedata_unused;

  // Only the low WIDTH bits of writedata carry register content.
  assign writedata_unused = writedata;

  assign wr_en  = chipselect && !write_n;
  assign primed = (prime_cnt == 2'd3);

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_cond = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_cond = ~sync2 & prev;
    end else begin : g_any
      assign edge_cond = sync2 ^ prev;
    end

    if (IRQ_TYPE == 0) begin : g_irq_edge
      assign irq_next = |(edge_capture & irq_mask);
    end else begin : g_irq_level
      assign irq_next = |(sync2 & irq_mask);
    end
  endgenerate

  // A fresh edge in the same cycle as its clear keeps the bit set.
  assign clear_mask = (wr_en && reg_addr_e'(address) == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign edge_next  = (edge_capture & ~clear_mask) | (primed ? edge_cond : '0);

  always_comb begin
    // NOTE: default first so every path assigns read_mux and no latch is inferred.
    read_mux = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: read_mux[WIDTH-1:0] = sync2;
      ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
      ADDR_NONE: read_mux = '0;
      default:   read_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      prime_cnt    <= 2'd0;
      readdata     <= 32'd0;
      irq          <= 1'b0;
    end else begin
      sync1        <= in_port;
      sync2        <= sync1;
      prev         <= sync2;
      edge_capture <= edge_next;
      readdata     <= read_mux;
      irq          <= irq_next;
      // Edge detection waits until sync1/sync2/prev all hold post-reset samples.
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
      end
      if (wr_en && reg_addr_e'(address) == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pio_in_capture.sv
// Bench for pio_in_capture: four builds (rise/fall/any edge, 32-bit level irq) on a shared bus,
// checked against a sample-history reference model through directed and random steps.
module tb_pio_in_capture;

  localparam int NI = 4;
  localparam logic [31:0] WMASK [NI] = '{32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF};
  localparam int EDGE_T [NI] = '{0, 1, 2, 0};
  localparam int IRQ_T  [NI] = '{0, 0, 0, 1};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in8;
  logic [31:0] in32;

  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int checks   = 0;
  int failures = 0;

  // Reference model: every sampled input value since reset release, plus register images.
  logic [31:0] hist8 [$];
  logic [31:0] hist32 [$];
  logic [31:0] m_mask [NI];
  logic [31:0] m_cap  [NI];
  logic [31:0] m_rd   [NI];
  logic        m_irq  [NI];

  always #5 clk = ~clk;

  pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8), .readdata(rd0), .irq(irq0));

  pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(0)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8), .readdata(rd1), .irq(irq1));

  pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(0)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8), .readdata(rd2), .irq(irq2));

  pio_in_capture #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32), .readdata(rd3), .irq(irq3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist8.delete();
    hist32.delete();
    for (int i = 0; i < NI; i++) begin
      m_mask[i] = '0;
      m_cap[i]  = '0;
      m_rd[i]   = '0;
      m_irq[i]  = 1'b0;
    end
  endtask

  // Input value sampled at clock edge j (1-based since reset release); 0 before any sample.
  function automatic logic [31:0] samp(input int i, input int j);
    if (j < 1) return 32'd0;
    return (i == 3) ? hist32[j-1] : hist8[j-1];
  endfunction

  // Edge n registers the sample from edge n-2 as data; an edge is the change between the
  // samples of edges n-3 and n-2, counted only once both are genuine post-reset samples.
  task automatic model_step();
    int          n;
    logic        wr;
    logic [31:0] cur, old, cond, det, clr;
    hist8.push_back({24'd0, in8});
    hist32.push_back(in32);
    n  = hist8.size();
    wr = chipselect && !write_n;
    for (int i = 0; i < NI; i++) begin
      cur = samp(i, n - 2);
      old = samp(i, n - 3);
      case (EDGE_T[i])
        0:       cond = cur & ~old;
        1:       cond = ~cur & old;
        default: cond = cur ^ old;
      endcase
      det = (n >= 4) ? (cond & WMASK[i]) : 32'd0;
      clr = (wr && address == 2'd2) ? (writedata & WMASK[i]) : 32'd0;
      case (address)
        2'd0:    m_rd[i] = cur;
        2'd1:    m_rd[i] = m_mask[i];
        2'd2:    m_rd[i] = m_cap[i];
        default: m_rd[i] = 32'd0;
      endcase
      m_irq[i] = (IRQ_T[i] == 1) ? |(cur & m_mask[i]) : |(m_cap[i] & m_mask[i]);
      m_cap[i] = (m_cap[i] & ~clr) | det;
      if (wr && address == 2'd1) m_mask[i] = writedata & WMASK[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] rd [NI];
    logic        iq [NI];
    rd = '{rd0, rd1, rd2, rd3};
    iq = '{irq0, irq1, irq2, irq3};
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_rd%0d", tag, i), rd[i], m_rd[i]);
      check($sformatf("%s_irq%0d", tag, i), {31'd0, iq[i]}, {31'd0, m_irq[i]});
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in8        = 8'hFF;
    in32       = 32'd0;
    model_reset();

    // Reset and priming with a static-high input.
    ticks(3);
    check_all("reset");
    reset_n = 1'b1;
    ticks(10);
    check("prime_data", rd0, 32'h0000_00FF);
    check_all("prime");
    address = 2'd2;
    tick();
    check("prime_cap_rise", rd0, 32'd0);
    check("prime_cap_fall", rd1, 32'd0);
    check("prime_cap_any", rd2, 32'd0);
    check_all("prime_cap");

    // Rising capture and edge-mode irq latency.
    bus_write(2'd1, 32'h0000_0005);
    in8 = 8'h00;
    ticks(5);
    bus_write(2'd2, 32'hFFFF_FFFF);
    ticks(2);
    check("rise_idle", rd0, 32'd0);
    in8 = 8'h04;
    ticks(3);
    check("rise_irq_k2", {31'd0, irq0}, 32'd0);
    tick();
    check("rise_cap_k3", rd0, 32'h0000_0004);
    check("rise_irq_k3", {31'd0, irq0}, 32'd1);
    in8 = 8'h00;
    ticks(4);
    check("rise_sticky", rd0, 32'h0000_0004);
    check_all("rise");

    // Clear, then a clear colliding with a new rising edge.
    bus_write(2'd2, 32'h0000_0004);
    check("clr_irq_k", {31'd0, irq0}, 32'd1);
    tick();
    check("clr_irq_k1", {31'd0, irq0}, 32'd0);
    check("clr_cap", rd0, 32'd0);
    in8 = 8'h04;
    ticks(2);
    bus_write(2'd2, 32'h0000_0004);
    tick();
    check("collide_cap", rd0, 32'h0000_0004);
    check_all("collide");

    // Mask gating.
    in8 = 8'h00;
    ticks(5);
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    in8 = 8'h80;
    ticks(5);
    address = 2'd2;
    tick();
    check("gate_cap", rd0, 32'h0000_0080);
    check("gate_irq_off", {31'd0, irq0}, 32'd0);
    bus_write(2'd1, 32'h0000_0080);
    check("gate_irq_k", {31'd0, irq0}, 32'd0);
    tick();
    check("gate_irq_k1", {31'd0, irq0}, 32'd1);
    check_all("gate");

    // Falling and any-edge builds.
    in8 = 8'hF0;
    ticks(5);
    bus_write(2'd2, 32'hFFFF_FFFF);
    in8 = 8'h30;
    ticks(5);
    address = 2'd2;
    tick();
    check("fall_cap", rd1, 32'h0000_00C0);
    in8 = 8'h0F;
    ticks(5);
    bus_write(2'd2, 32'hFFFF_FFFF);
    in8 = 8'hF0;
    ticks(5);
    address = 2'd2;
    tick();
    check("any_cap", rd2, 32'h0000_00FF);
    check_all("modes");

    // Level irq on the 32-bit build.
    bus_write(2'd1, 32'h8000_0000);
    in32 = 32'h8000_0000;
    ticks(2);
    check("lvl_irq_k1", {31'd0, irq3}, 32'd0);
    tick();
    check("lvl_irq_k2", {31'd0, irq3}, 32'd1);
    in32 = 32'd0;
    ticks(2);
    check("lvl_hold_k1", {31'd0, irq3}, 32'd1);
    tick();
    check("lvl_drop_k2", {31'd0, irq3}, 32'd0);
    check_all("lvl");

    // Unused address and zero extension of narrow builds.
    address = 2'd3;
    tick();
    check("addr3_rise", rd0, 32'd0);
    check("addr3_lvl", rd3, 32'd0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    check("mask_ext8", rd0, 32'h0000_00FF);
    check("mask_w32", rd3, 32'hFFFF_FFFF);
    check_all("ext");

    // Asynchronous reset in mid-operation, then priming again.
    in8 = 8'hAA;
    ticks(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    in8 = 8'h55;
    ticks(3);
    reset_n = 1'b1;
    address = 2'd2;
    ticks(10);
    check("reprime_cap", rd0, 32'd0);
    address = 2'd0;
    tick();
    check("reprime_data", rd0, 32'h0000_0055);
    check_all("reprime");

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom();
      if ($urandom_range(0, 1) == 0) in8 = 8'($urandom());
      if ($urandom_range(0, 2) == 0) in32 = $urandom();
      tick();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
